// File: rtl/bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_ctrl
//
// Stopwatch controller driving a cascaded chain of DIGITS one-digit BCD
// counters. A prescaler produces the count tick every TICK_DIV cycles while
// running, and a run/pause/lap/clear FSM gates the chain. A lap register
// freezes the displayed value while the live count keeps advancing.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start_stop  one-cycle pulse: toggle run/pause
//   lap         one-cycle pulse: freeze/unfreeze the display
//   clear       one-cycle pulse: zero the count (honoured only in PAUSE)
//   count       live BCD count, digit i at bits [4i+3:4i]
//   display     lap value while in LAP, otherwise equal to count
//   running     high in RUN or LAP
//   lap_active  high in LAP
//   overflow    sticky flag, set when the whole chain wraps 99..9 -> 00..0
// ---------------------------------------------------------------------------
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_stop,
  input  logic                lap,
  input  logic                clear,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] display,
  output logic                running,
  output logic                lap_active,
  output logic                overflow
);

  // Keep the prescaler at least one bit wide so TICK_DIV=1 still elaborates.
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [4*DIGITS-1:0] lap_q, lap_d;
  logic                overflow_q, overflow_d;

  logic counting;
  logic tick;
  logic do_clear;

  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = counting && (presc_q == PRESC_MAX);

  // Next state. clear is only meaningful in PAUSE, where it beats start_stop;
  // elsewhere start_stop beats lap.
  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    do_clear = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (start_stop) state_d = S_PAUSE;
        else if (lap)   state_d = S_LAP;
      end
      S_LAP: begin
        if (start_stop) state_d = S_PAUSE;
        else if (lap)   state_d = S_RUN;
      end
      S_PAUSE: begin
        if (clear) begin
          state_d  = S_IDLE;
          do_clear = 1'b1;
        end else if (start_stop) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler: free-runs in RUN/LAP, holds its phase in PAUSE, and is only
  // zeroed by clear (IDLE is always entered with it already at zero).
  always_comb begin
    presc_d = presc_q;
    if (counting)      presc_d = tick ? '0 : presc_q + PW'(1);
    else if (do_clear) presc_d = '0;
  end

  // Digit cascade: the carry ripples upward through every digit sitting at 9.
  // A carry out of the top digit is the overflow event.
  always_comb begin
    logic carry;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    carry      = tick;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (digits_q[4*i +: 4] == 4'd9) begin
          digits_d[4*i +: 4] = 4'd0;
        end else begin
          digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    if (carry) overflow_d = 1'b1;
    if (do_clear) begin
      digits_d   = '0;
      overflow_d = 1'b0;
    end
  end

  // Lap capture takes the post-increment count so the frozen value matches
  // what count shows right after the lap edge.
  always_comb begin
    lap_d = lap_q;
    if ((state_q == S_RUN) && !start_stop && lap) lap_d = digits_d;
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      digits_q   <= '0;
      lap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      lap_q      <= lap_d;
      overflow_q <= overflow_d;
    end
  end

  assign count      = digits_q;
  assign display    = (state_q == S_LAP) ? lap_q : digits_q;
  assign running    = counting;
  assign lap_active = (state_q == S_LAP);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_stopwatch_ctrl
//
// Three instances (4 digits / div 4, 4 digits / div 1, 2 digits / div 1) share
// one stimulus stream. A behavioural model (integer count modulo 10^DIGITS)
// predicts each instance; predictions are queued when inputs are driven and
// popped after the following clock edge. Directed checks with fixed
// expectations cover latency, carries, lap, pause phase, clear and overflow.
// ---------------------------------------------------------------------------
module tb_bcd_stopwatch_ctrl;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_LAP   = 2;
  localparam int ST_PAUSE = 3;

  typedef struct {
    int st;
    int presc;
    int cnt;
    int lapv;
    bit ovf;
  } model_t;

  typedef struct packed {
    logic [15:0] count;
    logic [15:0] display;
    logic        running;
    logic        lap_active;
    logic        overflow;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ss, lp, cl;

  logic [15:0] c0, d0, c1, d1;
  logic [7:0]  c2, d2;
  logic [2:0]  run_o, lapa_o, ovf_o;

  int checks = 0;
  int errors = 0;

  model_t m[3];
  int     td_a[3]   = '{4, 1, 1};
  int     modv_a[3] = '{10000, 10000, 100};
  int     dig_a[3]  = '{4, 4, 2};
  exp_t   sb_q[$];

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.DIGITS(4), .TICK_DIV(4)) u_d4t4 (
    .clk(clk), .reset(reset), .start_stop(ss), .lap(lp), .clear(cl),
    .count(c0), .display(d0), .running(run_o[0]), .lap_active(lapa_o[0]),
    .overflow(ovf_o[0])
  );

  bcd_stopwatch_ctrl #(.DIGITS(4), .TICK_DIV(1)) u_d4t1 (
    .clk(clk), .reset(reset), .start_stop(ss), .lap(lp), .clear(cl),
    .count(c1), .display(d1), .running(run_o[1]), .lap_active(lapa_o[1]),
    .overflow(ovf_o[1])
  );

  bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(1)) u_d2t1 (
    .clk(clk), .reset(reset), .start_stop(ss), .lap(lp), .clear(cl),
    .count(c2), .display(d2), .running(run_o[2]), .lap_active(lapa_o[2]),
    .overflow(ovf_o[2])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v, input int d);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      if (i < d) r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic model_t reset_model();
    model_t r;
    r.st = ST_IDLE; r.presc = 0; r.cnt = 0; r.lapv = 0; r.ovf = 1'b0;
    return r;
  endfunction

  // One clock edge of the reference behaviour, from the pre-edge state.
  function automatic model_t step(input model_t cur, input bit s, input bit l,
                                  input bit c, input int td, input int modv);
    model_t n;
    bit     act;
    bit     tick;
    n    = cur;
    act  = (cur.st == ST_RUN) || (cur.st == ST_LAP);
    tick = act && (cur.presc == td - 1);
    if (act) n.presc = tick ? 0 : cur.presc + 1;
    if (tick) begin
      if (cur.cnt == modv - 1) begin
        n.cnt = 0;
        n.ovf = 1'b1;
      end else begin
        n.cnt = cur.cnt + 1;
      end
    end
    case (cur.st)
      ST_IDLE: if (s) n.st = ST_RUN;
      ST_RUN: begin
        if (s) n.st = ST_PAUSE;
        else if (l) begin
          n.st   = ST_LAP;
          n.lapv = n.cnt;
        end
      end
      ST_LAP: begin
        if (s) n.st = ST_PAUSE;
        else if (l) n.st = ST_RUN;
      end
      default: begin
        if (c) begin
          n.st = ST_IDLE; n.cnt = 0; n.presc = 0; n.ovf = 1'b0;
        end else if (s) n.st = ST_RUN;
      end
    endcase
    return n;
  endfunction

  function automatic exp_t expect_of(input model_t mm, input int d);
    exp_t e;
    e.count      = to_bcd(mm.cnt, d);
    e.display    = (mm.st == ST_LAP) ? to_bcd(mm.lapv, d) : e.count;
    e.running    = (mm.st == ST_RUN) || (mm.st == ST_LAP);
    e.lap_active = (mm.st == ST_LAP);
    e.overflow   = mm.ovf;
    return e;
  endfunction

  function automatic exp_t actual(input int i);
    exp_t a;
    case (i)
      0:       begin a.count = c0;          a.display = d0;          end
      1:       begin a.count = c1;          a.display = d1;          end
      default: begin a.count = {8'h00, c2}; a.display = {8'h00, d2}; end
    endcase
    a.running    = run_o[i];
    a.lap_active = lapa_o[i];
    a.overflow   = ovf_o[i];
    return a;
  endfunction

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    check({tag, "_count"},   32'(a.count),      32'(e.count));
    check({tag, "_display"}, 32'(a.display),    32'(e.display));
    check({tag, "_running"}, 32'(a.running),    32'(e.running));
    check({tag, "_lap"},     32'(a.lap_active), 32'(e.lap_active));
    check({tag, "_ovf"},     32'(a.overflow),   32'(e.overflow));
  endtask

  // Called at posedge+1 (or just after reset release): drive, predict, push,
  // then pop and compare after the next rising edge.
  task automatic cycle(input bit s, input bit l, input bit c);
    exp_t e;
    ss = s; lp = l; cl = c;
    for (int i = 0; i < 3; i++) begin
      m[i] = step(m[i], s, l, c, td_a[i], modv_a[i]);
      sb_q.push_back(expect_of(m[i], dig_a[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        compare($sformatf("sb%0d", i), actual(i), e);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    exp_t z;
    z = '0;
    for (int i = 0; i < 3; i++) compare($sformatf("%s%0d", tag, i), actual(i), z);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = reset_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ss = 1'b0; lp = 1'b0; cl = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_init");
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a lap, between edges and mid-prescale.
    cycle(1, 0, 0);
    repeat (6) cycle(0, 0, 0);
    cycle(0, 1, 0);
    check("lap_before_rst", 32'(lapa_o[0]), 32'd1);
    repeat (2) cycle(0, 0, 0);
    async_reset("rst_lap");

    // Start latency and prescaler phase (div 4), fast carries (div 1).
    cycle(1, 0, 0);
    check("run_after_start", 32'(run_o[0]), 32'd1);
    repeat (3) cycle(0, 0, 0);
    check("d4t4_before_tick", 32'(c0), 32'h0000);
    cycle(0, 0, 0);
    check("d4t4_first_tick", 32'(c0), 32'h0001);
    repeat (4) cycle(0, 0, 0);
    check("d4t4_second_tick", 32'(c0), 32'h0002);
    cycle(0, 0, 0);
    check("d4t1_nine", 32'(c1), 32'h0009);
    cycle(0, 0, 0);
    check("d4t1_ten", 32'(c1), 32'h0010);
    repeat (89) cycle(0, 0, 0);
    check("d4t1_99", 32'(c1), 32'h0099);
    check("d2t1_99", 32'(c2), 32'h99);
    check("d2t1_no_ovf", 32'(ovf_o[2]), 32'd0);
    cycle(0, 0, 0);
    check("d4t1_100", 32'(c1), 32'h0100);
    check("d2t1_wrap", 32'(c2), 32'h00);
    check("d2t1_ovf", 32'(ovf_o[2]), 32'd1);
    check("d2t1_still_run", 32'(run_o[2]), 32'd1);
    check("d4t4_25", 32'(c0), 32'h0025);

    // clear is ignored while running.
    cycle(0, 0, 1);
    check("clear_in_run", 32'(c1), 32'h0101);

    // Lap freezes the display on the post-increment value.
    cycle(0, 1, 0);
    check("lap_active", 32'(lapa_o[1]), 32'd1);
    check("lap_capture", 32'(d1), 32'h0102);
    repeat (8) cycle(0, 0, 0);
    check("lap_live_count", 32'(c1), 32'h0110);
    check("lap_held", 32'(d1), 32'h0102);
    cycle(0, 1, 0);
    check("lap_release", 32'(d1), 32'h0111);

    // Pause mid-prescale: tick on the pause edge applies, phase is kept.
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("pause_tick_applied", 32'(c1), 32'h0113);
    check("pause_not_running", 32'(run_o[1]), 32'd0);
    repeat (5) cycle(0, 0, 0);
    cycle(0, 1, 0);
    check("pause_lap_ignored", 32'(lapa_o[1]), 32'd0);
    check("pause_frozen", 32'(c1), 32'h0113);
    check("pause_frozen_d4t4", 32'(c0), 32'h0028);
    cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);
    check("resume_phase_wait", 32'(c0), 32'h0028);
    cycle(0, 0, 0);
    check("resume_phase_tick", 32'(c0), 32'h0029);

    // start_stop + clear together in PAUSE: clear wins.
    cycle(1, 0, 0);
    cycle(1, 0, 1);
    check("clear_count", 32'(c1), 32'h0000);
    check("clear_running", 32'(run_o[1]), 32'd0);
    check("clear_ovf", 32'(ovf_o[2]), 32'd0);
    check("clear_d4t4", 32'(c0), 32'h0000);

    // Random pulse traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0);
    end

    // Second reset while lapping mid-prescale.
    cycle(0, 0, 0);
    if (m[0].st != ST_RUN && m[0].st != ST_LAP) cycle(1, 0, 0);
    if (m[0].st == ST_LAP) cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    async_reset("rst_lap2");
    cycle(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
Stopwatch controller that sequences a cascaded chain of DIGITS one-digit BCD counters. A prescaler generates the count tick, and a run/pause/lap/clear FSM gates the chain. Digit cascade enables are generated here. A lap-capture register freezes the displayed value while counting continues. It sits between debounced, single-cycle button pulses and the 7-segment display mux.

Parameters:
DIGITS, 4, number of BCD digits (>=1); digit 0 is least significant.
TICK_DIV, 10, clk cycles per count increment (>=1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start_stop  input  1  one-cycle pulse: toggle run/pause.
lap  input  1  one-cycle pulse: freeze/unfreeze display.
clear  input  1  one-cycle pulse: zero the count (honoured only in PAUSE).
count  output  4*DIGITS  live BCD count; digit i occupies bits [4i+3:4i].
display  output  4*DIGITS  lap value in LAP state, otherwise equals count.
running  output  1  high in RUN or LAP.
lap_active  output  1  high in LAP.
overflow  output  1  sticky wrap flag.

Behaviour:
- Reset (async, any time, mid-count included): state=IDLE, prescaler=0, all digits=0, lap register=0, overflow=0. Consequently count=0, display=0, running=0, lap_active=0.
- All updates occur on the rising clk edge and use the state held before that edge.
- FSM states: IDLE, RUN, LAP, PAUSE.
- IDLE: start_stop -> RUN. lap and clear are ignored.
- RUN: start_stop -> PAUSE. Otherwise lap -> LAP, capturing count into the lap register on the same edge (post-increment value if a tick occurs on that edge). clear is ignored.
- LAP: start_stop -> PAUSE, and display returns to live. Otherwise lap -> RUN. clear is ignored. Counting continues throughout.
- PAUSE: clear -> IDLE, zeroing digits, prescaler and overflow. Otherwise start_stop -> RUN. lap is ignored.
- Simultaneous pulses, priority: clear > start_stop > lap. At most one transition per edge.
- Prescaler: advances only in RUN/LAP over 0..TICK_DIV-1. It wraps to 0 on the tick edge, where tick = (prescaler==TICK_DIV-1) and state is RUN or LAP.
  - Prescaler holds its value in PAUSE, so a resumed run keeps sub-tick phase.
  - Prescaler is 0 in IDLE.
  - For TICK_DIV=1, tick fires on every RUN/LAP cycle.
- Latency: RUN entered at edge k from IDLE gives the first increment (count=1) at edge k+TICK_DIV.
- A tick on the edge that leaves RUN for PAUSE is still applied.
- Cascade rules:
  - Digit 0 increments on tick.
  - Digit i>0 increments on tick when all lower digits == 9.
  - Each digit wraps 9 -> 0.
  - Digits never hold values 10-15.
- Overflow: a tick with all digits == 9 sets every digit to 0 and sets overflow=1. Overflow stays set until clear (from PAUSE) or reset. Counting continues after overflow.
- display: registered lap value in LAP; combinationally equal to count in every other state.
- Output width: count and display are exactly 4*DIGITS bits, with no unused bits.

Test Plan:
1. DIGITS=4, TICK_DIV=4. Assert reset mid-operation, release, pulse start_stop at edge k -> running=1; count=0001 at edge k+4, 0002 at k+8; prescaler phase verified.
2. DIGITS=4, TICK_DIV=1. Run from 0 for 9 cycles -> count=0009. Next edge -> 0010. After 100 total ticks -> 0100, carry cascades correctly, no digit exceeds 9.
3. Lap: in RUN at count=0012, pulse lap -> lap_active=1, display holds 0012 while count advances to 0020. Pulse lap again -> display tracks count live.
4. Pause/clear: in RUN, pulse clear -> ignored. Pulse start_stop -> PAUSE, count frozen, prescaler phase held. Pulse start_stop+clear in the same cycle -> IDLE, count=0000, running=0.
5. Overflow: DIGITS=2, TICK_DIV=1. Run 99 ticks -> count=99. Next tick -> count=00, overflow=1, still running. Pause, clear -> overflow=0.
6. Async reset in LAP mid-prescale (between clock edges) -> all outputs 0 immediately, without waiting for a clk edge.
